// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program memory fetch unit with decode handshake, branch redirect and halt
module instruction_fetch #(
  parameter int                 AWIDTH   = 15,
  parameter int                 DWIDTH   = 32,
  parameter logic [AWIDTH-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DWIDTH-1:0] mem_data,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_en,
  input  logic [AWIDTH-1:0] branch_target,
  input  logic              halt,
  output logic [15:0]       fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LATCH,
    HOLD,
    HALTED
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AWIDTH-1:0] pc;
  logic              pc_load_target;
  logic              pc_inc;
  logic              capture;
  logic              accept;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control; a branch outranks halt everywhere except HALTED
  always_comb begin
    state_nxt      = state;
    pc_load_target = 1'b0;
    pc_inc         = 1'b0;
    capture        = 1'b0;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        if (branch_en) begin
          pc_load_target = 1'b1;
          state_nxt      = IDLE;
        end else if (halt) begin
          state_nxt = HALTED;
        end else begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (branch_en) begin
          pc_load_target = 1'b1;
          state_nxt      = IDLE;
        end else if (halt) begin
          state_nxt = HALTED;
        end else begin
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        if (branch_en) begin
          pc_load_target = 1'b1;
          state_nxt      = IDLE;
        end else if (halt) begin
          state_nxt = HALTED;
        end else begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          accept = 1'b1;
          if (branch_en) begin
            pc_load_target = 1'b1;
            state_nxt      = IDLE;
          end else begin
            pc_inc    = 1'b1;
            state_nxt = halt ? HALTED : REQ;
          end
        end else if (branch_en) begin
          pc_load_target = 1'b1;
          state_nxt      = IDLE;
        end
      end
      HALTED: begin
        if (branch_en) begin
          pc_load_target = 1'b1;
        end
        if (!halt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Program counter, instruction capture and saturating accept counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr     <= '0;
      instr_pc  <= '0;
      fetch_cnt <= '0;
    end else begin
      if (pc_load_target) begin
        pc <= branch_target;
      end else if (pc_inc) begin
        pc <= pc + AWIDTH'(1);
      end
      if (capture) begin
        instr    <= mem_data;
        instr_pc <= pc;
      end
      if (accept && (fetch_cnt != 16'hFFFF)) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
    end
  end

  // Outputs are gated by reset so memory and decode see a quiet interface during reset
  assign mem_rd      = rst_n && ((state == REQ) || (state == LATCH));
  assign instr_valid = rst_n && (state == HOLD);
  assign mem_addr    = rst_n ? pc : RESET_PC;
  assign mem_wr      = 1'b0;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_data;
  logic [31:0] instr;
  logic [14:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [14:0] branch_target;
  logic        halt;
  logic [15:0] fetch_cnt;

  logic [3:0]  mem_addr2;
  logic        mem_rd2;
  logic        mem_wr2;
  logic [31:0] mem_data2;
  logic [31:0] instr2;
  logic [3:0]  instr_pc2;
  logic        instr_valid2;
  logic [15:0] fetch_cnt2;

  logic [31:0] mem [0:31];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_en(branch_en), .branch_target(branch_target),
    .halt(halt), .fetch_cnt(fetch_cnt)
  );

  instruction_fetch #(.AWIDTH(4), .DWIDTH(32), .RESET_PC(4'd15)) dut_w (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
    .mem_data(mem_data2), .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .instr_ready(1'b1), .branch_en(1'b0), .branch_target(4'd0),
    .halt(1'b0), .fetch_cnt(fetch_cnt2)
  );

  // Registered-read program memory: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr[4:0]];
  end

  assign mem_data2 = {28'h1234000, mem_addr2};

  function automatic logic [31:0] word(input int a);
    return (a == 0) ? 32'hA5A5_0001 : (32'hC0DE_0000 + 32'(a));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = word(i);
    rst_n = 1'b0; instr_ready = 1'b1; branch_en = 1'b0; branch_target = '0; halt = 1'b0;
    step; step;
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);

    rst_n = 1'b1;
    chk("c0_mem_rd", mem_rd, 0);
    chk("c0_valid", instr_valid, 0);
    chk("c0_addr", mem_addr, 0);
    step;
    chk("c1_mem_rd", mem_rd, 1);
    chk("c1_addr", mem_addr, 0);
    step;
    chk("c2_mem_rd", mem_rd, 1);
    chk("c2_addr", mem_addr, 0);
    chk("c2_valid", instr_valid, 0);
    step;
    chk("c3_valid", instr_valid, 1);
    chk("c3_instr", instr, 32'hA5A5_0001);
    chk("c3_instr_pc", instr_pc, 0);
    chk("c3_mem_rd", mem_rd, 0);
    chk("w_c3_instr_pc", instr_pc2, 15);
    chk("w_c3_instr", instr2, 32'h1234_000F);
    step;
    chk("c4_cnt", fetch_cnt, 1);
    chk("c4_valid", instr_valid, 0);
    chk("c4_mem_rd", mem_rd, 1);
    chk("c4_addr", mem_addr, 1);
    chk("w_wrap_addr", mem_addr2, 0);
    chk("w_cnt", fetch_cnt2, 1);

    // Decode stalls for five cycles, accepts on the sixth
    instr_ready = 1'b0;
    step; step;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", instr_valid, 1);
      chk("stall_instr", instr, word(1));
      chk("stall_instr_pc", instr_pc, 1);
      chk("stall_mem_rd", mem_rd, 0);
      chk("stall_pc", mem_addr, 1);
      chk("stall_cnt", fetch_cnt, 1);
      step;
    end
    chk("stall6_valid", instr_valid, 1);
    instr_ready = 1'b1;
    step;
    instr_ready = 1'b0;
    chk("post_stall_cnt", fetch_cnt, 2);
    chk("post_stall_rd", mem_rd, 1);
    chk("post_stall_addr", mem_addr, 2);

    // Branch during LATCH aborts the fetch
    step;
    chk("latch_rd", mem_rd, 1);
    branch_en = 1'b1; branch_target = 15'd7;
    step;
    branch_en = 1'b0;
    chk("br_idle_rd", mem_rd, 0);
    chk("br_idle_valid", instr_valid, 0);
    chk("br_idle_addr", mem_addr, 7);
    step;
    chk("br_req_rd", mem_rd, 1);
    chk("br_req_addr", mem_addr, 7);
    step; step;
    chk("br_hold_valid", instr_valid, 1);
    chk("br_hold_instr", instr, word(7));
    chk("br_hold_pc", instr_pc, 7);
    chk("br_hold_cnt", fetch_cnt, 2);

    // Branch together with acceptance in HOLD
    instr_ready = 1'b1; branch_en = 1'b1; branch_target = 15'd3;
    step;
    instr_ready = 1'b0; branch_en = 1'b0;
    chk("brh_cnt", fetch_cnt, 3);
    chk("brh_rd", mem_rd, 0);
    chk("brh_valid", instr_valid, 0);
    chk("brh_addr", mem_addr, 3);
    step;
    chk("brh_req_rd", mem_rd, 1);
    chk("brh_req_addr", mem_addr, 3);

    // Halt during REQ for four cycles, then refetch of the same address
    halt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("halt_rd", mem_rd, 0);
      chk("halt_valid", instr_valid, 0);
      chk("halt_addr", mem_addr, 3);
    end
    halt = 1'b0;
    step;
    chk("unhalt_idle_rd", mem_rd, 0);
    step;
    chk("refetch_rd", mem_rd, 1);
    chk("refetch_addr", mem_addr, 3);
    step; step;
    chk("refetch_valid", instr_valid, 1);
    chk("refetch_instr", instr, word(3));

    // Halt in HOLD keeps the instruction until it is accepted
    halt = 1'b1;
    step;
    chk("halt_hold_valid", instr_valid, 1);
    chk("halt_hold_instr", instr, word(3));
    instr_ready = 1'b1;
    step;
    instr_ready = 1'b0;
    chk("halt_acc_cnt", fetch_cnt, 4);
    chk("halt_acc_valid", instr_valid, 0);
    chk("halt_acc_addr", mem_addr, 4);

    // Branch while HALTED updates pc only
    branch_en = 1'b1; branch_target = 15'd9;
    step;
    branch_en = 1'b0; halt = 1'b0;
    chk("hbr_rd", mem_rd, 0);
    chk("hbr_addr", mem_addr, 9);
    step;
    chk("hbr_idle_rd", mem_rd, 0);
    step;
    chk("hbr_req_rd", mem_rd, 1);
    chk("hbr_req_addr", mem_addr, 9);
    step; step;
    chk("hbr_valid", instr_valid, 1);
    chk("hbr_instr", instr, word(9));

    // Reset mid-HOLD discards the held instruction
    rst_n = 1'b0;
    step;
    chk("mr_valid", instr_valid, 0);
    chk("mr_cnt", fetch_cnt, 0);
    chk("mr_instr", instr, 0);
    chk("mr_instr_pc", instr_pc, 0);
    chk("mr_addr", mem_addr, 0);
    chk("mr_rd", mem_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
